ram_wr_arbiter: RTL and testbench
=================================

# ram_wr_arbiter

Write-side arbiter and sequencer for the `buffer_ram_dp` frame buffer. It shares the single RAM write port between two pixel producers, requester 0 (camera capture) and requester 1 (test-pattern/debug source). Ownership is granted per frame, with round-robin fairness and an inactivity timeout. The block generates the write address, `regwrite` strobe and write data for the RAM. The read side (`addr_out`, `regread`) is untouched and stays with the display logic.

## Interface
Parameters:
- `AW`, 15: RAM address width.
- `DW`, 8: pixel/data width.
- `LAST_ADDR`, 19199: final address of a frame (160×120 − 1); must be < 2^AW.
- `TIMEOUT`, 1024: idle cycles an owner may go without `valid` before ownership is revoked (≥ 2).

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid0`, `valid1` in 1: requester i has a beat.
- `sof0`, `sof1` in 1: beat is first pixel of a frame; qualified by `valid_i`.
- `data0`, `data1` in DW: pixel data.
- `ready0`, `ready1` out 1: beat accepted this cycle when `valid_i & ready_i`.
- `addr_in` out AW: RAM write address (registered).
- `data_in` out DW: RAM write data (registered).
- `regwrite` out 1: RAM write enable (registered).
- `owner` out 2: 00 none, 01 requester 0, 10 requester 1.
- `frame_done` out 1: one-cycle pulse, full frame written.
- `abort` out 1: one-cycle pulse, ownership revoked by timeout.
- `drop0`, `drop1` out 1: one-cycle pulse, non-owner beat discarded.

## Operation
- States: IDLE, OWN0, OWN1. Reset state IDLE; round-robin pointer `rr` = 0 (requester 0 preferred).
- IDLE:
  - A requester with `valid_i & sof_i` is a candidate. If both are candidates, pick `rr`; otherwise pick the single candidate. Go to OWNi next cycle.
  - The sof beat is not consumed in IDLE: `ready_i` = 0 for it, and it is accepted in OWNi.
  - A beat with `valid_i & ~sof_i` in IDLE is discarded: `ready_i` = 1 and `drop_i` pulses.
- OWNi:
  - `ready_i` = 1. The non-owner j gets `ready_j = valid_j & ~sof_j` and `drop_j` pulses for each such beat. Non-owner sof beats stall (`ready_j` = 0).
  - Accepted beat: write `data_i` at `ptr`. If `sof_i`, the write goes to address 0 and `ptr` ← 1 (frame restart). Otherwise `ptr` ← `ptr` + 1.
  - Write at `LAST_ADDR`: `frame_done` pulses, `ptr` ← 0, state ← IDLE, `rr` ← other requester.
  - Idle counter counts cycles with `valid_i` = 0 and resets on any accepted beat. On reaching `TIMEOUT`: `abort` pulses, `ptr` ← 0, state ← IDLE, `rr` ← other requester.
- `ptr` never exceeds `LAST_ADDR`; wrap to 0 occurs only via frame completion, sof or abort.
- `owner` is a decoded function of state.

## Timing
- `ready_i` is combinational from state and `valid`/`sof` only, with no path from `data`.
- Accepted beat in cycle t gives `regwrite` = 1 with `addr_in`/`data_in` valid in cycle t+1. Latency is exactly 1 cycle; throughput is 1 beat/cycle.
- `regwrite` = 0 in every cycle following a cycle with no accepted owner beat. Dropped beats never write.
- `frame_done`/`abort` are asserted in cycle t+1 together with the final write (or the timeout transition).
- Grant latency: sof presented in IDLE at cycle t, OWNi at t+1, sof beat written at t+2.
- Reset values: `regwrite` 0, `addr_in` 0, `data_in` 0, `owner` 00, `ready*` 0, all pulses 0, `ptr` 0, idle counter 0.
- Reset asserted mid-frame clears everything immediately (async). A partially written frame is abandoned with no `frame_done`.
- Simultaneous final write and owner sof: sof wins. Address 0 is written, `ptr` ← 1, and the state stays OWNi with no `frame_done`.

## Structure
- Shared package: owner encoding constants (`OWN_NONE`, `OWN_0`, `OWN_1`), state encoding, and default `AW`/`DW`/`LAST_ADDR` for the 160×120 buffer.
- One natural sub-module: `frame_addr_ctr`. It holds the `ptr` counter with load-0/load-1/increment and a last-address flag. The FSM, round-robin and timeout logic stay in the top.

## Test plan
- Requester 0 alone sends sof plus 19199 beats back-to-back. Required: addresses 0..19199 each written once, `frame_done` after the last, `owner` returns to 00.
- Both assert sof in the same cycle after reset. Required: requester 0 granted first. After its frame completes, requester 1 (still holding sof) is granted within 1 cycle of IDLE.
- Requester 1 streams non-sof beats while requester 0 owns. Required: each gets `drop1`, with no `regwrite` from requester 1.
- Owner stops after 100 beats and `TIMEOUT` = 1024 elapses. Required: `abort` pulses at idle cycle 1024, state returns to IDLE, and the other requester is preferred next.
- Owner re-asserts sof at `ptr` = 500. Required: the next write goes to address 0, the following one to address 1, and there is no `frame_done`.
- `rst` asserted low mid-frame. Required: outputs go to reset values asynchronously, and after release a new sof restarts at address 0.

Source files
------------

// File: rtl/ram_wr_arbiter_pkg.sv
// Shared definitions for the frame-buffer write arbiter: owner codes, FSM states
// and default geometry of the 160x120 buffer.
package ram_wr_arbiter_pkg;

    localparam int unsigned AW_DEF        = 15;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned LAST_ADDR_DEF = 19199;
    localparam int unsigned TIMEOUT_DEF   = 1024;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_0    = 2'b01;
    localparam logic [1:0] OWN_1    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    // Owner code shown to the outside world for a given FSM state.
    function automatic logic [1:0] owner_of(state_e s);
        logic [1:0] o;
        case (s)
            ST_OWN0: o = OWN_0;
            ST_OWN1: o = OWN_1;
            default: o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Bundle of requester handshakes, RAM write port and status pulses of the
// write arbiter. master = producers/RAM side, slave = arbiter.
interface ram_wr_arbiter_if
    import ram_wr_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          valid0;
    logic          valid1;
    logic          sof0;
    logic          sof1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          ready0;
    logic          ready1;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic [1:0]    owner;
    logic          frame_done;
    logic          abort;
    logic          drop0;
    logic          drop1;

    modport master (
        output valid0, valid1, sof0, sof1, data0, data1,
        input  ready0, ready1, addr_in, data_in, regwrite, owner,
               frame_done, abort, drop0, drop1
    );

    modport slave (
        input  valid0, valid1, sof0, sof1, data0, data1,
        output ready0, ready1, addr_in, data_in, regwrite, owner,
               frame_done, abort, drop0, drop1
    );

endinterface

// File: rtl/ram_wr_arbiter_frame_addr_ctr.sv
// Frame write pointer: load-0 / load-1 / increment with a last-address flag.
module frame_addr_ctr
    import ram_wr_arbiter_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load0,
    input  logic          load1,
    input  logic          inc,
    output logic [AW-1:0] ptr,
    output logic          is_last
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    assign is_last = (ptr_q == AW'(LAST_ADDR));
    assign ptr     = ptr_q;

    // A frame restart (load1) takes priority; increment wraps at the last address.
    always_comb begin
        ptr_d = ptr_q;
        if (load1) begin
            ptr_d = AW'(1);
        end else if (load0) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = is_last ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Per-frame round-robin owner of the frame-buffer RAM write port, with
// inactivity timeout; drives registered address/data/write strobe.
module ram_wr_arbiter
    import ram_wr_arbiter_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned LAST_ADDR = LAST_ADDR_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    ram_wr_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(TIMEOUT);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          frame_done_q, frame_done_d;
    logic          abort_q, abort_d;
    logic          drop0_q, drop0_d;
    logic          drop1_q, drop1_d;

    logic          ready0_c, ready1_c;
    logic          cand0, cand1;
    logic          own_sel, own_v, own_s;
    logic [DW-1:0] own_data;
    logic          load0, load1, inc;
    logic [AW-1:0] ptr;
    logic          is_last;

    frame_addr_ctr #(
        .AW        (AW),
        .LAST_ADDR (LAST_ADDR)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .load0   (load0),
        .load1   (load1),
        .inc     (inc),
        .ptr     (ptr),
        .is_last (is_last)
    );

    // Next-state, handshake and write-port decode.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        idle_d       = idle_q;
        regwrite_d   = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        load0        = 1'b0;
        load1        = 1'b0;
        inc          = 1'b0;

        cand0    = bus.valid0 & bus.sof0;
        cand1    = bus.valid1 & bus.sof1;
        own_sel  = (state_q == ST_OWN1);
        own_v    = own_sel ? bus.valid1 : bus.valid0;
        own_s    = own_sel ? bus.sof1   : bus.sof0;
        own_data = own_sel ? bus.data1  : bus.data0;

        // Non-owner non-sof beats are swallowed; sof beats stall until granted.
        ready0_c = (state_q == ST_OWN0) | (bus.valid0 & ~bus.sof0);
        ready1_c = (state_q == ST_OWN1) | (bus.valid1 & ~bus.sof1);
        drop0_d  = bus.valid0 & ~bus.sof0 & (state_q != ST_OWN0);
        drop1_d  = bus.valid1 & ~bus.sof1 & (state_q != ST_OWN1);

        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (cand0 && cand1) begin
                    state_d = rr_q ? ST_OWN1 : ST_OWN0;
                end else if (cand0) begin
                    state_d = ST_OWN0;
                end else if (cand1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (own_v) begin
                    regwrite_d = 1'b1;
                    data_d     = own_data;
                    idle_d     = '0;
                    if (own_s) begin
                        addr_d = '0;
                        load1  = 1'b1;
                    end else begin
                        addr_d = ptr;
                        if (is_last) begin
                            frame_done_d = 1'b1;
                            load0        = 1'b1;
                            state_d      = ST_IDLE;
                            rr_d         = ~own_sel;
                        end else begin
                            inc = 1'b1;
                        end
                    end
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    load0   = 1'b1;
                    idle_d  = '0;
                    state_d = ST_IDLE;
                    rr_d    = ~own_sel;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            idle_q       <= '0;
            regwrite_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            drop0_q      <= 1'b0;
            drop1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            idle_q       <= idle_d;
            regwrite_q   <= regwrite_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
            drop0_q      <= drop0_d;
            drop1_q      <= drop1_d;
        end
    end

    assign bus.ready0     = ready0_c;
    assign bus.ready1     = ready1_c;
    assign bus.addr_in    = addr_q;
    assign bus.data_in    = data_q;
    assign bus.regwrite   = regwrite_q;
    assign bus.owner      = owner_of(state_q);
    assign bus.frame_done = frame_done_q;
    assign bus.abort      = abort_q;
    assign bus.drop0      = drop0_q;
    assign bus.drop1      = drop1_q;

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboard bench for ram_wr_arbiter: a transaction-level model predicts each
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_ram_wr_arbiter;
    import ram_wr_arbiter_pkg::*;

    localparam int unsigned AW   = AW_DEF;
    localparam int unsigned DW   = DW_DEF;
    localparam int          LAST = int'(LAST_ADDR_DEF);
    localparam int          TO   = int'(TIMEOUT_DEF);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_wr_arbiter #(
        .AW(AW), .DW(DW), .LAST_ADDR(LAST_ADDR_DEF), .TIMEOUT(TIMEOUT_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit wr;
        int addr;
        int data;
        bit fd;
        bit ab;
        bit dr0;
        bit dr1;
        int own;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;
    int   wr_cnt[LAST+1];
    int   fd_cnt = 0, ab_cnt = 0, drop1_cnt = 0;

    // Reference model: owner 0 = nobody, 1 = requester 0, 2 = requester 1.
    int   m_own, m_ptr, m_rr, m_idle;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per cycle, popped just after the edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (bus.regwrite && int'(bus.addr_in) <= LAST) wr_cnt[bus.addr_in]++;
            fd_cnt    += int'(bus.frame_done);
            ab_cnt    += int'(bus.abort);
            drop1_cnt += int'(bus.drop1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("regwrite", int'(bus.regwrite), int'(mon_e.wr));
                if (mon_e.wr) begin
                    check("addr_in", int'(bus.addr_in), mon_e.addr);
                    check("data_in", int'(bus.data_in), mon_e.data);
                end
                check("frame_done", int'(bus.frame_done), int'(mon_e.fd));
                check("abort", int'(bus.abort), int'(mon_e.ab));
                check("drop0", int'(bus.drop0), int'(mon_e.dr0));
                check("drop1", int'(bus.drop1), int'(mon_e.dr1));
                check("owner", int'(bus.owner), mon_e.own);
            end else begin
                check("idle_regwrite", int'(bus.regwrite), 0);
            end
        end
    end

    task automatic model_reset();
        m_own = 0; m_ptr = 0; m_rr = 0; m_idle = 0;
    endtask

    // Drive one cycle of stimulus, check ready, predict next-cycle outputs.
    task automatic step(input bit v0, input bit s0, input int d0,
                        input bit v1, input bit s1, input int d1);
        exp_t e;
        bit   v[2], s[2], r[2];
        int   d[2];
        int   o, j;
        @(negedge clk);
        bus.valid0 = v0; bus.sof0 = s0; bus.data0 = DW'(d0);
        bus.valid1 = v1; bus.sof1 = s1; bus.data1 = DW'(d1);
        #3;
        v[0] = v0; v[1] = v1; s[0] = s0; s[1] = s1; d[0] = d0 & 255; d[1] = d1 & 255;
        e = '{default: 0};
        r[0] = v[0] && !s[0];
        r[1] = v[1] && !s[1];
        if (m_own == 0) begin
            e.dr0 = r[0];
            e.dr1 = r[1];
            if (v[0] && s[0] && v[1] && s[1]) m_own = m_rr + 1;
            else if (v[0] && s[0])            m_own = 1;
            else if (v[1] && s[1])            m_own = 2;
        end else begin
            o = m_own - 1;
            j = 1 - o;
            if (j == 0) e.dr0 = r[0]; else e.dr1 = r[1];
            r[o] = 1'b1;
            if (v[o]) begin
                e.wr = 1'b1; e.data = d[o]; m_idle = 0;
                if (s[o]) begin
                    e.addr = 0; m_ptr = 1;
                end else begin
                    e.addr = m_ptr;
                    if (m_ptr == LAST) begin
                        e.fd = 1'b1; m_ptr = 0; m_own = 0; m_rr = j;
                    end else begin
                        m_ptr++;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    e.ab = 1'b1; m_ptr = 0; m_own = 0; m_rr = j; m_idle = 0;
                end
            end
        end
        e.own = m_own;
        check("ready0", int'(bus.ready0), int'(r[0]));
        check("ready1", int'(bus.ready1), int'(r[1]));
        exp_q.push_back(e);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        bus.valid0 = 0; bus.sof0 = 0; bus.data0 = '0;
        bus.valid1 = 0; bus.sof1 = 0; bus.data1 = '0;
        rst = 1'b0;
        #1;
        check("rst_regwrite", int'(bus.regwrite), 0);
        check("rst_addr_in", int'(bus.addr_in), 0);
        check("rst_data_in", int'(bus.data_in), 0);
        check("rst_owner", int'(bus.owner), 0);
        check("rst_pulses", int'({bus.frame_done, bus.abort, bus.drop0, bus.drop1}), 0);
        check("rst_ready", int'({bus.ready0, bus.ready1}), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    int exp_drop, ok, fd_saved, b;

    initial begin
        rst = 1'b1;
        bus.valid0 = 0; bus.sof0 = 0; bus.data0 = '0;
        bus.valid1 = 0; bus.sof1 = 0; bus.data1 = '0;
        model_reset();
        #1 rst = 1'b0;
        do_reset();

        // Requester 0 alone writes a full frame.
        foreach (wr_cnt[i]) wr_cnt[i] = 0;
        fd_cnt = 0;
        step(1, 1, $urandom, 0, 0, 0);
        step(1, 1, $urandom, 0, 0, 0);
        for (int k = 1; k <= LAST; k++) step(1, 0, $urandom, 0, 0, 0);
        idle_steps(2);
        ok = 0;
        foreach (wr_cnt[i]) if (wr_cnt[i] == 1) ok++;
        check("frame_each_addr_once", ok, LAST + 1);
        check("frame_done_count", fd_cnt, 1);
        check("owner_after_frame", int'(bus.owner), 0);

        // Simultaneous sof: requester 0 first, then requester 1.
        do_reset();
        fd_cnt = 0;
        step(1, 1, $urandom, 1, 1, $urandom);
        @(posedge clk); #2;
        check("both_sof_grant0", int'(bus.owner), 1);
        step(1, 1, $urandom, 1, 1, $urandom);
        for (int k = 1; k <= LAST; k++) step(1, 0, $urandom, 1, 1, $urandom);
        step(0, 0, 0, 1, 1, $urandom);
        @(posedge clk); #2;
        check("grant1_after_frame", int'(bus.owner), 2);
        check("frame_done_req0", fd_cnt, 1);

        // Requester 1 owns, stops after 100 beats, times out.
        ab_cnt = 0;
        step(0, 0, 0, 1, 1, $urandom);
        for (int k = 1; k < 100; k++) step(0, 0, 0, 1, 0, $urandom);
        idle_steps(TO - 1);
        @(posedge clk); #2;
        check("no_abort_before_timeout", ab_cnt, 0);
        idle_steps(1);
        @(posedge clk); #2;
        check("abort_count", ab_cnt, 1);
        check("owner_after_abort", int'(bus.owner), 0);
        step(1, 1, $urandom, 1, 1, $urandom);
        @(posedge clk); #2;
        check("rr_after_abort", int'(bus.owner), 1);

        // Requester 0 restarts its frame at ptr 500 while requester 1 is dropped.
        fd_cnt = 0; drop1_cnt = 0;
        step(1, 1, $urandom, 1, 0, $urandom);
        exp_drop = 1;
        for (int k = 1; k < 500; k++) begin
            b = int'($urandom_range(0, 1));
            step(1, 0, $urandom, b[0], 0, $urandom);
            exp_drop += b;
        end
        step(1, 1, $urandom, 0, 0, 0);
        @(posedge clk); #2;
        check("resof_addr0", int'(bus.addr_in), 0);
        step(1, 0, $urandom, 0, 0, 0);
        @(posedge clk); #2;
        check("resof_addr1", int'(bus.addr_in), 1);
        check("resof_no_done", fd_cnt, 0);
        check("drop1_count", drop1_cnt, exp_drop);

        // Random traffic from both requesters.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 4) != 0, ($urandom % 64) == 0, $urandom,
                 ($urandom % 4) != 0, ($urandom % 64) == 0, $urandom);
        end

        // Reset mid-frame, then a clean restart at address 0.
        do_reset();
        step(1, 1, $urandom, 0, 0, 0);
        step(1, 1, $urandom, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 0, $urandom, 0, 0, 0);
        fd_saved = fd_cnt;
        do_reset();
        step(1, 1, $urandom, 0, 0, 0);
        step(1, 1, $urandom, 0, 0, 0);
        @(posedge clk); #2;
        check("restart_addr0", int'(bus.addr_in), 0);
        check("restart_regwrite", int'(bus.regwrite), 1);
        check("no_done_on_reset", fd_cnt, fd_saved);

        idle_steps(3);
        @(posedge clk); #2;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
